// File: rtl/zion_riscv_isa_lib_slt_decode_stage.sv
// rtl/zion_riscv_isa_lib_slt_decode_stage.sv - SLT/branch-compare decode and operand latch stage
// Optional build macro: ZION_RISCV_SLT_DE_SKID_EN (adds a 2-entry skid buffer with registered ready)
module zion_riscv_isa_lib_slt_decode_stage #(
  parameter int RV64 = 0,
  localparam int CPU_WIDTH = 32 * (RV64 + 1)
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iFlush,
  input  logic                 iInstrVld,
  output logic                 oInstrRdy,
  input  logic [31:0]          iInstr,
  input  logic [CPU_WIDTH-1:0] iRs1Dat,
  input  logic [CPU_WIDTH-1:0] iRs2Dat,
  output logic                 oVld,
  input  logic                 iRdy,
  output logic                 oEn,
  output logic                 oUnsignedFlg,
  output logic [CPU_WIDTH-1:0] oS1,
  output logic [CPU_WIDTH-1:0] oS2,
  output logic                 oBrFlg,
  output logic                 oInvFlg,
  output logic [4:0]           oRd
);

  typedef struct packed {
    logic                 en;
    logic                 uns;
    logic                 br;
    logic                 inv;
    logic [4:0]           rd;
    logic [CPU_WIDTH-1:0] s1;
    logic [CPU_WIDTH-1:0] s2;
  } bundle_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_slt_imm;
  logic       is_slt_reg;
  logic       is_branch;
  logic       unused_rs1_field;
  bundle_t    dec;
  logic       in_xfer;
  logic       out_xfer;

  assign opcode = iInstr[6:0];
  assign funct3 = iInstr[14:12];
  assign funct7 = iInstr[31:25];
  // rs1 index is resolved by the register file upstream; only its data is used here
  assign unused_rs1_field = ^iInstr[19:15];

  assign is_slt_imm = (opcode == 7'b0010011) && (funct3[2:1] == 2'b01);
  assign is_slt_reg = (opcode == 7'b0110011) && (funct7 == 7'b0000000) && (funct3[2:1] == 2'b01);
  assign is_branch  = (opcode == 7'b1100011) && funct3[2];

  // Decode the instruction into the execute bundle; unsupported ops yield an all-zero bundle
  always_comb begin
    dec = '0;
    if (is_slt_imm || is_slt_reg) begin
      dec.en  = 1'b1;
      dec.uns = funct3[0];
      dec.rd  = iInstr[11:7];
      dec.s1  = iRs1Dat;
      dec.s2  = is_slt_imm ? {{(CPU_WIDTH-12){iInstr[31]}}, iInstr[31:20]} : iRs2Dat;
    end else if (is_branch) begin
      dec.en  = 1'b1;
      dec.br  = 1'b1;
      dec.uns = funct3[1];
      dec.inv = funct3[0];
      dec.s1  = iRs1Dat;
      dec.s2  = iRs2Dat;
    end
  end

  logic    vld_q, vld_d;
  bundle_t out_q, out_d;

  assign in_xfer  = iInstrVld & oInstrRdy;
  assign out_xfer = vld_q & iRdy;

`ifdef ZION_RISCV_SLT_DE_SKID_EN
  logic    skid_vld_q, skid_vld_d;
  logic    rdy_q, rdy_d;
  bundle_t skid_q, skid_d;

  assign oInstrRdy = rdy_q;

  // Output register plus one skid entry; the skid entry always drains into the output first
  always_comb begin
    vld_d      = vld_q;
    out_d      = out_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (iFlush) begin
      vld_d      = 1'b0;
      skid_vld_d = 1'b0;
    end else if (out_xfer) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        skid_vld_d = in_xfer;
        if (in_xfer) begin
          skid_d = dec;
        end
      end else begin
        vld_d = in_xfer;
        if (in_xfer) begin
          out_d = dec;
        end
      end
    end else if (in_xfer) begin
      if (!vld_q) begin
        vld_d = 1'b1;
        out_d = dec;
      end else begin
        skid_vld_d = 1'b1;
        skid_d     = dec;
      end
    end
    rdy_d = ~skid_vld_d;
  end

  // Skid state and registered ready; ready comes up on the first edge after reset release
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
      rdy_q      <= 1'b0;
    end else begin
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
      rdy_q      <= rdy_d;
    end
  end
`else
  assign oInstrRdy = ~vld_q | iRdy;

  // Single output register; a same-cycle drain and accept replaces the contents without a bubble
  always_comb begin
    vld_d = vld_q;
    out_d = out_q;
    if (iFlush) begin
      vld_d = 1'b0;
    end else if (in_xfer) begin
      vld_d = 1'b1;
      out_d = dec;
    end else if (out_xfer) begin
      vld_d = 1'b0;
    end
  end
`endif

  // Output register seen by the execute stage
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      vld_q <= 1'b0;
      out_q <= '0;
    end else begin
      vld_q <= vld_d;
      out_q <= out_d;
    end
  end

  assign oVld         = vld_q;
  assign oEn          = out_q.en;
  assign oUnsignedFlg = out_q.uns;
  assign oBrFlg       = out_q.br;
  assign oInvFlg      = out_q.inv;
  assign oRd          = out_q.rd;
  assign oS1          = out_q.s1;
  assign oS2          = out_q.s2;

endmodule

// File: tb/tb_zion_riscv_isa_lib_slt_decode_stage.sv
// tb/tb_zion_riscv_isa_lib_slt_decode_stage.sv - randomized check of RV32 and RV64 decode stages against a queue model
module tb_zion_riscv_isa_lib_slt_decode_stage;

`ifdef ZION_RISCV_SLT_DE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic        iFlush;
  logic        iInstrVld;
  logic [31:0] iInstr;
  logic [63:0] rs1_dat;
  logic [63:0] rs2_dat;
  logic        iRdy;

  logic        r32_rdy, r32_vld, r32_en, r32_uns, r32_br, r32_inv;
  logic [31:0] r32_s1, r32_s2;
  logic [4:0]  r32_rd;
  logic        r64_rdy, r64_vld, r64_en, r64_uns, r64_br, r64_inv;
  logic [63:0] r64_s1, r64_s2;
  logic [4:0]  r64_rd;

  always #5 iClk = ~iClk;

  zion_riscv_isa_lib_slt_decode_stage #(.RV64(0)) u_dut32 (
    .iClk(iClk), .iRst_n(iRst_n), .iFlush(iFlush), .iInstrVld(iInstrVld), .oInstrRdy(r32_rdy),
    .iInstr(iInstr), .iRs1Dat(rs1_dat[31:0]), .iRs2Dat(rs2_dat[31:0]), .oVld(r32_vld), .iRdy(iRdy),
    .oEn(r32_en), .oUnsignedFlg(r32_uns), .oS1(r32_s1), .oS2(r32_s2), .oBrFlg(r32_br),
    .oInvFlg(r32_inv), .oRd(r32_rd)
  );

  zion_riscv_isa_lib_slt_decode_stage #(.RV64(1)) u_dut64 (
    .iClk(iClk), .iRst_n(iRst_n), .iFlush(iFlush), .iInstrVld(iInstrVld), .oInstrRdy(r64_rdy),
    .iInstr(iInstr), .iRs1Dat(rs1_dat), .iRs2Dat(rs2_dat), .oVld(r64_vld), .iRdy(iRdy),
    .oEn(r64_en), .oUnsignedFlg(r64_uns), .oS1(r64_s1), .oS2(r64_s2), .oBrFlg(r64_br),
    .oInvFlg(r64_inv), .oRd(r64_rd)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] rs1;
    logic [63:0] rs2;
  } item_t;

  typedef struct {
    bit        en, uns, br, inv;
    bit [4:0]  rd;
    bit [63:0] s1, s2;
  } exp_t;

  item_t q[$];
  bit    started;
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference semantics by mnemonic: what each supported instruction hands to the compare unit
  function automatic exp_t model(input item_t it, input bit w64);
    exp_t        e;
    bit   [63:0] mask;
    bit   [6:0]  opc;
    int          f3;
    longint      imm;
    e    = '{default: 0};
    mask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    opc  = it.instr[6:0];
    f3   = int'(it.instr[14:12]);
    imm  = longint'($signed(it.instr[31:20]));
    if (opc == 7'h13 && (f3 == 2 || f3 == 3)) begin
      e.en = 1; e.uns = (f3 == 3); e.rd = it.instr[11:7];
      e.s1 = it.rs1 & mask; e.s2 = 64'(imm) & mask;
    end else if (opc == 7'h33 && it.instr[31:25] == 7'h00 && (f3 == 2 || f3 == 3)) begin
      e.en = 1; e.uns = (f3 == 3); e.rd = it.instr[11:7];
      e.s1 = it.rs1 & mask; e.s2 = it.rs2 & mask;
    end else if (opc == 7'h63 && f3 >= 4) begin
      e.en = 1; e.br = 1; e.uns = (f3 >= 6); e.inv = (f3 == 5 || f3 == 7);
      e.s1 = it.rs1 & mask; e.s2 = it.rs2 & mask;
    end
    return e;
  endfunction

  task automatic check_outputs();
    exp_t e32, e64;
    check("vld32", r32_vld, q.size() != 0);
    check("vld64", r64_vld, q.size() != 0);
    if (q.size() != 0) begin
      e32 = model(q[0], 1'b0);
      e64 = model(q[0], 1'b1);
      check("en32", r32_en, e32.en);   check("en64", r64_en, e64.en);
      check("uns32", r32_uns, e32.uns); check("uns64", r64_uns, e64.uns);
      check("br32", r32_br, e32.br);   check("br64", r64_br, e64.br);
      check("inv32", r32_inv, e32.inv); check("inv64", r64_inv, e64.inv);
      check("rd32", r32_rd, e32.rd);   check("rd64", r64_rd, e64.rd);
      check("s1_32", r32_s1, e32.s1);  check("s1_64", r64_s1, e64.s1);
      check("s2_32", r32_s2, e32.s2);  check("s2_64", r64_s2, e64.s2);
    end
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_vld"}, {r32_vld, r64_vld}, 0);
    check({tag, "_flags"}, {r32_en, r32_uns, r32_br, r32_inv, r64_en, r64_uns, r64_br, r64_inv}, 0);
    check({tag, "_rd"}, {r32_rd, r64_rd}, 0);
    check({tag, "_s32"}, {r32_s1, r32_s2}, 0);
    check({tag, "_s1_64"}, r64_s1, 0);
    check({tag, "_s2_64"}, r64_s2, 0);
  endtask

  // One clock cycle: called at a falling edge, returns at the next falling edge
  task automatic step(input logic vld, input logic [31:0] instr, input logic [63:0] rs1,
                      input logic [63:0] rs2, input logic rdy, input logic flush);
    bit    exp_rdy, acc, pop;
    item_t it;
    iInstrVld = vld; iInstr = instr; rs1_dat = rs1; rs2_dat = rs2; iRdy = rdy; iFlush = flush;
    #1;
    exp_rdy = SKID ? (started && q.size() < 2) : (q.size() == 0 || rdy);
    check("rdy32", r32_rdy, exp_rdy);
    check("rdy64", r64_rdy, exp_rdy);
    acc = vld && exp_rdy;
    pop = (q.size() != 0) && rdy;
    it  = '{instr: instr, rs1: rs1, rs2: rs2};
    @(posedge iClk);
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(it);
    end
    started = 1'b1;
    @(negedge iClk);
    check_outputs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [4:0]  rd, r1, r2;
    rd = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom);
    case ($urandom_range(0, 5))
      0: w = {12'($urandom), r1, 2'b01, 1'($urandom), rd, 7'h13};
      1: w = {7'h00, r2, r1, 2'b01, 1'($urandom), rd, 7'h33};
      2: w = {7'($urandom), r2, r1, 1'b1, 2'($urandom), rd, 7'h63};
      3: w = {7'h00, r2, r1, 3'($urandom), rd, 7'h33};
      4: w = {7'h20, r2, r1, 3'b010, rd, 7'h33};
      default: w = $urandom;
    endcase
    return w;
  endfunction

  localparam logic [31:0] SLT_X3 = {7'h00, 5'd2, 5'd1, 3'b010, 5'd3, 7'h33};

  initial begin
    iRst_n = 1'b0; iFlush = 1'b0; iInstrVld = 1'b0; iInstr = '0;
    rs1_dat = '0; rs2_dat = '0; iRdy = 1'b0; started = 1'b0;
    #12;
    check_reset_zero("reset");
    @(negedge iClk);
    iRst_n = 1'b1;
    step(0, 32'h0, 64'h0, 64'h0, 1, 0);

    // SLTI x5,x1,-1
    step(1, 32'hFFF0A293, 64'h3, 64'h0, 1, 0);
    check("tp1_s2_32", r32_s2, 64'hFFFF_FFFF);
    check("tp1_rd", r32_rd, 5);
    check("tp1_en_uns_br", {r32_en, r32_uns, r32_br}, 3'b100);
    // SLTIU with imm 0x800
    step(1, {12'h800, 5'd1, 3'b011, 5'd6, 7'h13}, 64'h5, 64'h0, 1, 0);
    check("tp2_s2_64", r64_s2, 64'hFFFF_FFFF_FFFF_F800);
    check("tp2_uns_en", {r64_uns, r64_en}, 2'b11);
    // BGEU
    step(1, {7'h00, 5'd2, 5'd1, 3'b111, 5'd9, 7'h63}, 64'h10, 64'h20, 1, 0);
    check("tp3_flags", {r64_br, r64_inv, r64_uns, r64_rd}, {3'b111, 5'd0});
    check("tp3_ops", {r32_s1, r32_s2}, {32'h10, 32'h20});
    // ADD is unsupported
    step(1, {7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33}, 64'h77, 64'h88, 1, 0);
    check("tp4", {r64_vld, r64_en, r64_rd}, {2'b10, 5'd0});
    check("tp4_ops", r64_s1 | r64_s2, 0);
    step(0, 32'h0, 64'h0, 64'h0, 1, 0);

    // Backpressure for three cycles, then drain
    for (int i = 0; i < 3; i++) step(1, SLT_X3, 64'(i + 1), 64'(i + 10), 0, 0);
    check("bp_rdy", r32_rdy, 0);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 64'h0, 64'h0, 1, 0);

    // Flush colliding with an accept while the output holds a valid instruction
    step(1, SLT_X3, 64'h1, 64'h2, 0, 0);
    step(1, SLT_X3, 64'h3, 64'h4, 0, 1);
    check("flush_vld", {r32_vld, r64_vld}, 0);
    step(0, 32'h0, 64'h0, 64'h0, 1, 0);

    // Reset asserted mid-stall
    step(1, SLT_X3, 64'h5, 64'h6, 0, 0);
    step(1, SLT_X3, 64'h7, 64'h8, 0, 0);
    #2 iRst_n = 1'b0;
    #1 check_reset_zero("midrst");
    q.delete();
    started = 1'b0;
    @(negedge iClk);
    iRst_n = 1'b1;

    for (int i = 0; i < 500; i++) begin
      step(1'($urandom), rand_instr(), {$urandom, $urandom}, {$urandom, $urandom},
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
